// File: rtl/adc_capture_pkg.sv
// Shared types and widths for the ADC-to-USB capture path.
// Used by adc_sample_packer and adc_usb_capture.
package adc_capture_pkg;

  localparam int SAMPLES_PER_WORD  = 4;
  localparam int LANE_WIDTH        = $clog2(SAMPLES_PER_WORD);
  localparam int ADC_SAMPLE_WIDTH  = 8;
  localparam int USB_WORD_WIDTH    = 32;
  localparam int ADC_DECIM_WIDTH   = 16;
  localparam int ADC_OVF_WIDTH     = 16;
  localparam int CAPTURE_LEN_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } capture_state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ADC_OVF_WIDTH-1:0] sat_inc(input logic [ADC_OVF_WIDTH-1:0] value);
    logic [ADC_OVF_WIDTH-1:0] result;
    result = value;
    if (value != {ADC_OVF_WIDTH{1'b1}}) begin
      result = value + 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/adc_sample_packer.sv
// Packs SAMPLES_PER_WORD kept samples into one word, first sample in the low lane.
// The word is presented combinationally in the same cycle as its last sample.
module adc_sample_packer
  import adc_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
  parameter int WORD_WIDTH   = USB_WORD_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  output logic [WORD_WIDTH-1:0]   word,
  output logic                    word_valid,
  output logic [LANE_WIDTH-1:0]   lane
);

  localparam int ACC_WIDTH = WORD_WIDTH - SAMPLE_WIDTH;
  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(SAMPLES_PER_WORD - 1);

  logic [ACC_WIDTH-1:0] acc;

  // Lower lanes are held in acc; the top lane comes straight from the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= '0;
      acc  <= '0;
    end else if (clear) begin
      lane <= '0;
      acc  <= '0;
    end else if (sample_valid) begin
      if (lane != LAST_LANE) begin
        acc[int'(lane)*SAMPLE_WIDTH +: SAMPLE_WIDTH] <= sample;
      end
      lane <= lane + 1'b1;
    end
  end

  always_comb begin
    word       = {sample, acc};
    word_valid = sample_valid && (lane == LAST_LANE) && !clear;
  end

endmodule

// File: rtl/adc_usb_capture.sv
// ADC capture path: decimate signed samples, pack 4 per word, push to the USB write FIFO.
// Optional rising-edge trigger on trig_level is built when ADC_CAPTURE_TRIG_EN is defined.
module adc_usb_capture
  import adc_capture_pkg::*;
#(
  parameter int SAMPLE_WIDTH = ADC_SAMPLE_WIDTH,
  parameter int WORD_WIDTH   = USB_WORD_WIDTH,
  parameter int DECIM_WIDTH  = ADC_DECIM_WIDTH,
  parameter int OVF_WIDTH    = ADC_OVF_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SAMPLE_WIDTH-1:0]      adc_data,
  input  logic                         adc_data_valid,
  input  logic                         start,
  input  logic                         stop,
  input  logic [CAPTURE_LEN_WIDTH-1:0] capture_len,
  input  logic [DECIM_WIDTH-1:0]       decim,
  input  logic [SAMPLE_WIDTH-1:0]      trig_level,
  output logic [WORD_WIDTH-1:0]        usb_wr_data,
  output logic                         usb_wr_data_valid,
  input  logic                         usb_wr_full,
  output logic                         busy,
  output logic                         done,
  output logic [CAPTURE_LEN_WIDTH-1:0] word_count,
  output logic [OVF_WIDTH-1:0]         overflow_count
);

  capture_state_t state, state_next;

  logic                         start_ok;
  logic                         arm_ready;
  logic                         trig_fire;
  logic                         decim_step;
  logic                         sample_take;
  logic [DECIM_WIDTH-1:0]       decim_cnt;
  logic [WORD_WIDTH-1:0]        packed_word;
  logic                         word_done;
  logic [LANE_WIDTH-1:0]        pack_lane;
  logic                         skid_full;
  logic [WORD_WIDTH-1:0]        skid_data;
  logic                         drain;
  logic                         drop;
  logic [CAPTURE_LEN_WIDTH-1:0] word_count_inc;
  logic                         len_hit;
  logic                         unused_lane;

  // A start while busy is ignored, and stop in the same cycle beats it.
  assign start_ok = start && !stop && ((state == IDLE) || (state == DONE));

`ifdef ADC_CAPTURE_TRIG_EN
  logic [SAMPLE_WIDTH-1:0] prev_sample;
  logic                    prev_valid;

  assign trig_fire = (state == ARMED) && adc_data_valid && !stop && prev_valid &&
                     ($signed(prev_sample) < $signed(trig_level)) &&
                     ($signed(adc_data) >= $signed(trig_level));
  assign arm_ready = trig_fire;

  // prev_valid stops the first sample after start from counting as a crossing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_sample <= '0;
      prev_valid  <= 1'b0;
    end else if (start_ok) begin
      prev_sample <= '0;
      prev_valid  <= 1'b0;
    end else if ((state == ARMED) && adc_data_valid) begin
      prev_sample <= adc_data;
      prev_valid  <= 1'b1;
    end
  end
`else
  logic unused_trig_level;

  assign unused_trig_level = ^trig_level;
  assign trig_fire         = 1'b0;
  assign arm_ready         = 1'b1;
`endif

  // The trigger sample counts as the first decimation step, so it is always kept.
  assign decim_step  = ((state == CAPTURE) && adc_data_valid) || trig_fire;
  assign sample_take = decim_step && (decim_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      decim_cnt <= '0;
    end else if (start_ok) begin
      decim_cnt <= '0;
    end else if (decim_step) begin
      if (decim_cnt == '0) begin
        decim_cnt <= decim;
      end else begin
        decim_cnt <= decim_cnt - 1'b1;
      end
    end
  end

  adc_sample_packer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .WORD_WIDTH   (WORD_WIDTH)
  ) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear        (start_ok),
    .sample_valid (sample_take),
    .sample       (adc_data),
    .word         (packed_word),
    .word_valid   (word_done),
    .lane         (pack_lane)
  );

  assign unused_lane = ^pack_lane;

  assign drain = skid_full && !usb_wr_full;
  assign drop  = word_done && skid_full && !drain;

  // One-deep skid: a new word may replace the one leaving this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      skid_full <= 1'b0;
      skid_data <= '0;
    end else if (word_done && (!skid_full || drain)) begin
      skid_full <= 1'b1;
      skid_data <= packed_word;
    end else if (drain) begin
      skid_full <= 1'b0;
    end
  end

  assign word_count_inc = word_count + 1'b1;
  assign len_hit        = word_done && (capture_len != '0) && (word_count_inc == capture_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count     <= '0;
      overflow_count <= '0;
    end else if (start_ok) begin
      word_count     <= '0;
      overflow_count <= '0;
    end else begin
      if (word_done) begin
        word_count <= word_count_inc;
      end
      if (drop) begin
        overflow_count <= sat_inc(overflow_count);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = ARMED;
      ARMED: begin
        if (stop) begin
          state_next = IDLE;
        end else if (arm_ready) begin
          state_next = CAPTURE;
        end
      end
      CAPTURE: if (stop || len_hit) state_next = FLUSH;
      FLUSH:   if (!skid_full) state_next = DONE;
      DONE:    if (start_ok) state_next = ARMED;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ARMED, CAPTURE, FLUSH: busy = 1'b1;
      DONE:                  done = 1'b1;
      default:               ;
    endcase
  end

  assign usb_wr_data       = skid_data;
  assign usb_wr_data_valid = drain;

endmodule

// File: doc/adc_usb_capture.md
Name: adc_usb_capture

Overview:
- ADC-to-host capture path, the upstream counterpart of the DAC channel's USB read FIFO.
- Takes 8-bit signed ADC samples, decimates them, and packs four samples into each 32-bit word.
- Pushes words onto the USB write stream with valid/full backpressure.
- Sits between the ADC input conditioning and the USB write FIFO, and is controlled from the channel register block.

Parameters:
- SAMPLE_WIDTH, 8: ADC sample width in bits.
- WORD_WIDTH, 32: USB word width in bits; must equal 4*SAMPLE_WIDTH.
- DECIM_WIDTH, 16: width of the decimation control.
- OVF_WIDTH, 16: width of the saturating overflow counter.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- adc_data  in  8  signed ADC sample.
- adc_data_valid  in  1  sample strobe.
- start  in  1  single-cycle pulse that arms a capture.
- stop  in  1  single-cycle pulse that aborts a capture.
- capture_len  in  32  words to capture; 0 means continuous.
- decim  in  16  keep 1 of every decim+1 valid samples.
- trig_level  in  8  signed trigger threshold (used only with ADC_CAPTURE_TRIG_EN).
- usb_wr_data  out  32  packed word.
- usb_wr_data_valid  out  1  word strobe, one cycle per word.
- usb_wr_full  in  1  downstream FIFO full.
- busy  out  1  high in ARMED, CAPTURE or FLUSH.
- done  out  1  high in DONE.
- word_count  out  32  words generated in the current capture, including dropped words.
- overflow_count  out  16  dropped words; saturates at 0xFFFF.

Behaviour:
- Reset: clk and reset as in the interface above (one clock; asynchronous, active-high reset). All outputs are 0, the state is IDLE, and the packer, skid register and counters are cleared.
- Reset mid-capture aborts immediately. Nothing is flushed.
- States:
  - IDLE: start goes to ARMED.
  - ARMED: trigger condition goes to CAPTURE; stop goes to IDLE.
  - CAPTURE: stop, or word_count reaching capture_len (capture_len != 0), goes to FLUSH.
  - FLUSH: an empty skid register goes to DONE.
  - DONE: start goes to ARMED.
- start while busy is ignored.
- start (from IDLE or DONE) clears word_count, overflow_count, the decimation counter and the packer.
- Decimation:
  - A counter advances on each adc_data_valid in CAPTURE.
  - A sample is kept when the counter is 0; the counter then reloads to decim.
  - decim=0 keeps every sample.
  - A decim change takes effect at the next reload.
- Packing:
  - The first kept sample goes to bits [7:0], the fourth to [31:24].
  - The word completes on the 4th kept sample, and word_count increments on that same cycle.
  - A stop before a word completes discards the partial word.
- Output handshake:
  - A completed word goes to the skid register.
  - usb_wr_data_valid is asserted in the cycle after completion when the skid is occupied and usb_wr_full=0. The skid then empties.
  - Sample-to-valid latency is 1 cycle with no backpressure.
  - While usb_wr_full=1 the word is held and valid stays low. The data is stable until presented.
- Overflow:
  - If a word completes while the skid is still occupied and not draining this cycle, the new word is dropped and overflow_count increments (saturating at 0xFFFF).
  - A dropped word still counts in word_count.
- Completion: capture_len is compared to word_count after increment, so capture_len=1 yields exactly one word.
- Continuous mode: capture_len=0 runs until stop. word_count wraps at 2^32 without effect.
- Simultaneous stop and word completion in one cycle: the word is kept, then the block goes to FLUSH.
- Simultaneous start and stop in IDLE: stop wins and the block stays in IDLE.

Optional Feature:
- Macro: ADC_CAPTURE_TRIG_EN.
- Defined:
  - ARMED waits for a rising crossing: previous kept-path sample < trig_level and current sample >= trig_level, both signed, with adc_data_valid high.
  - The crossing sample is the first sample of CAPTURE, i.e. bits [7:0] of word 0.
  - The decimation counter starts at this sample.
- Undefined:
  - ARMED goes to CAPTURE on the next clock unconditionally.
  - trig_level is unused; no comparator or previous-sample register is synthesized.

Decomposition:
- Package adc_capture_pkg holds:
  - the state enum capture_state_t (IDLE, ARMED, CAPTURE, FLUSH, DONE);
  - SAMPLES_PER_WORD=4;
  - localparam widths.
- One sub-module: adc_sample_packer. It takes sample/valid/clear and produces word/word_valid, plus the 2-bit lane counter.
- The FSM, decimation, skid register and counters stay in the top module.

Test Plan:
- Pack: decim=0, capture_len=2, samples 01..08 → words 0x04030201 then 0x08070605, one cycle after the 4th and 8th samples. done=1, word_count=2.
- Decimate: decim=2, capture_len=1, samples 00..0B → word 0x09060300.
- Backpressure: usb_wr_full=1 for 20 cycles with a 1-word/4-cycle input → first word held, later words dropped, overflow_count increments per drop. After full clears the held word is emitted unchanged.
- Stop: stop after 6 kept samples in continuous mode → exactly one word emitted, partial word discarded, done=1.
- Reset mid-CAPTURE with the skid occupied → all outputs 0 the same cycle, no valid afterwards.
- Trigger (ADC_CAPTURE_TRIG_EN): trig_level=0x10, samples F0,08,12,20,30,40 → first word 0x40302012.
